// File: rtl/i2c_wb_arbiter_if.sv
// Bus bundle between the requesters' wishbone masters, the arbiter and the
// I2C master core's wishbone slave port.
interface i2c_wb_arbiter_if #(
  parameter int NUM_REQ = 2
) ();
  // requester side
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   gnt;
  logic [3*NUM_REQ-1:0] m_adr;
  logic [8*NUM_REQ-1:0] m_dat;
  logic [NUM_REQ-1:0]   m_we;
  logic [NUM_REQ-1:0]   m_stb;
  logic [NUM_REQ-1:0]   m_cyc;
  logic [7:0]           m_rdat;
  logic [NUM_REQ-1:0]   m_ack;
  // i2c core side
  logic [2:0]           s_adr;
  logic [7:0]           s_dat;
  logic [7:0]           s_rdat;
  logic                 s_we;
  logic                 s_stb;
  logic                 s_cyc;
  logic                 s_ack;
  // watchdog release pulse
  logic                 timeout;

  // arbiter view
  modport slave (
    input  req, m_adr, m_dat, m_we, m_stb, m_cyc, s_rdat, s_ack,
    output gnt, m_rdat, m_ack, s_adr, s_dat, s_we, s_stb, s_cyc, timeout
  );

  // requesters plus core view
  modport master (
    output req, m_adr, m_dat, m_we, m_stb, m_cyc, s_rdat, s_ack,
    input  gnt, m_rdat, m_ack, s_adr, s_dat, s_we, s_stb, s_cyc, timeout
  );
endinterface

// File: rtl/i2c_wb_arbiter.sv
// Round-robin arbiter sharing one wishbone I2C master core between NUM_REQ
// requesters. A grant is held for a whole I2C transaction; a watchdog forces
// release if the core never acks a granted strobe.
//
// state   | meaning
// IDLE    | no grant; pick next eligible requester after last
// GRANT   | requester last_q owns the core bus
// RELEASE | one idle cycle between grants
module i2c_wb_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic               i_clk,
  input logic               i_reset_n,
  i2c_wb_arbiter_if.slave   bus
);

  localparam int         IW       = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] mask_q;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IW-1:0]      last_q;
  logic [IW-1:0]      pick;
  logic               pick_valid;
  logic [15:0]        wd_q;
  logic               timeout_q;
  logic               wd_fire;

  // Round-robin search: scan from farthest to nearest so the index right after last wins.
  always_comb begin
    eligible   = bus.req & ~mask_q;
    pick       = last_q;
    pick_valid = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (eligible[(int'(last_q) + i) % NUM_REQ]) begin
        pick       = IW'((int'(last_q) + i) % NUM_REQ);
        pick_valid = 1'b1;
      end
    end
    pick_oh       = '0;
    pick_oh[pick] = pick_valid;
  end

  // Watchdog expiry: the un-acked strobe has waited TIMEOUT_CYCLES-1 cycles; ack wins.
  assign wd_fire = (state_q == S_GRANT) && bus.s_stb && !bus.s_ack && (wd_q == WD_LIMIT);

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (pick_valid) state_d = S_GRANT;
      S_GRANT:   if (wd_fire || (!bus.req[last_q] && !bus.m_cyc[last_q])) state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Grant, rr pointer, fault mask and watchdog registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      gnt_q     <= '0;
      last_q    <= IW'(NUM_REQ - 1);
      mask_q    <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_fire;
      // a faulted requester stays masked until it drops its request
      mask_q    <= (mask_q & bus.req) | (wd_fire ? gnt_q : '0);
      if (state_q == S_IDLE && pick_valid) begin
        gnt_q  <= pick_oh;
        last_q <= pick;
      end else if (state_d != S_GRANT) begin
        gnt_q  <= '0;
      end
      if (state_q == S_GRANT && bus.s_stb && !bus.s_ack && !wd_fire) wd_q <= wd_q + 16'd1;
      else                                                            wd_q <= '0;
    end
  end

  // Bus mux: granted requester drives the core combinationally; idle bus otherwise.
  always_comb begin
    bus.s_adr = '0;
    bus.s_dat = '0;
    bus.s_we  = 1'b0;
    bus.s_stb = 1'b0;
    bus.s_cyc = 1'b0;
    bus.m_ack = '0;
    if (state_q == S_GRANT) begin
      bus.s_adr         = bus.m_adr[3*int'(last_q) +: 3];
      bus.s_dat         = bus.m_dat[8*int'(last_q) +: 8];
      bus.s_we          = bus.m_we[last_q];
      bus.s_stb         = bus.m_stb[last_q] & bus.m_cyc[last_q];
      bus.s_cyc         = bus.m_cyc[last_q];
      bus.m_ack[last_q] = bus.s_ack;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.timeout = timeout_q;
  assign bus.m_rdat  = bus.s_rdat;

endmodule
